counter_checker: RTL and testbench

//  Consumer end of the counter's count bus: observes a free-running Size-bit up-counter each clock,

---
 rtl/counter_checker_pkg.sv | 12 +
 rtl/sat_counter.sv | 31 +++
 rtl/counter_checker.sv | 171 +++++++++++++++++
 tb/tb_counter_checker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg: shared state encoding for the count-bus checker.
package counter_checker_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: async-reset incrementer that sticks at all-ones.
module sat_counter #(
    parameter int Width = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_checker.sv
// counter_checker: locks to an observed free-running counter and flags out-of-sequence samples.
// Define COUNTER_CHECKER_CAPTURE_EN to latch the first mismatching expected/observed pair.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int Size      = 5,
    parameter int LockLen   = 4,
    parameter int ErrWidth  = 16,
    parameter int WrapWidth = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [Size-1:0]      count_in,
    input  logic                 count_vld,
    input  logic                 dut_reset,
    output logic                 locked,
    output logic                 mismatch,
    output logic [Size-1:0]      expected,
    output logic [ErrWidth-1:0]  err_count,
    output logic [WrapWidth-1:0] wrap_count
`ifdef COUNTER_CHECKER_CAPTURE_EN
    ,
    output logic                 first_vld,
    output logic [Size-1:0]      first_exp,
    output logic [Size-1:0]      first_obs
`endif
);

    localparam int RunW = $clog2(LockLen + 1);
    localparam logic [RunW-1:0] LockRun = RunW'(LockLen);
    localparam logic [RunW-1:0] OneRun  = RunW'(1);
    localparam logic [Size-1:0] OneExp  = Size'(1);

    state_e          state_q, state_d;
    state_e          resync_st;
    logic [Size-1:0] expected_q, expected_d;
    logic [RunW-1:0] run_q, run_d;
    logic            locked_q, locked_d;
    logic            mismatch_q, mismatch_d;
    logic            hit;
    logic            err_inc;
    logic            wrap_inc;

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_d      = run_q;
        mismatch_d = 1'b0;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;
        hit        = (count_in == expected_q);
        resync_st  = (LockLen == 1) ? LOCKED : ACQ;
        if (dut_reset) begin
            // Counter held in reset: restart acquisition expecting 0.
            state_d    = ACQ;
            run_d      = '0;
            expected_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count_vld) begin
                        expected_d = count_in + OneExp;
                        run_d      = OneRun;
                        state_d    = resync_st;
                    end
                end
                ACQ: begin
                    expected_d = expected_q + OneExp;
                    if (count_vld) begin
                        if (hit) begin
                            run_d = run_q + OneRun;
                            if ((run_q + OneRun) >= LockRun) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            expected_d = count_in + OneExp;
                            run_d      = OneRun;
                            state_d    = resync_st;
                        end
                    end
                end
                LOCKED: begin
                    expected_d = expected_q + OneExp;
                    if (count_vld) begin
                        if (hit) begin
                            wrap_inc = (count_in == '0);
                        end else begin
                            mismatch_d = 1'b1;
                            err_inc    = 1'b1;
                            expected_d = count_in + OneExp;
                            run_d      = OneRun;
                            state_d    = resync_st;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            expected_q <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
        end
    end

    sat_counter #(.Width(ErrWidth)) u_err (
        .clock (clock),
        .reset (reset),
        .inc   (err_inc),
        .count (err_count)
    );

    sat_counter #(.Width(WrapWidth)) u_wrap (
        .clock (clock),
        .reset (reset),
        .inc   (wrap_inc),
        .count (wrap_count)
    );

    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign expected = expected_q;

`ifdef COUNTER_CHECKER_CAPTURE_EN
    logic            first_vld_q, first_vld_d;
    logic [Size-1:0] first_exp_q, first_exp_d;
    logic [Size-1:0] first_obs_q, first_obs_d;

    always_comb begin
        first_vld_d = first_vld_q;
        first_exp_d = first_exp_q;
        first_obs_d = first_obs_q;
        if (mismatch_d && !first_vld_q) begin
            first_vld_d = 1'b1;
            first_exp_d = expected_q;
            first_obs_d = count_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_vld_q <= 1'b0;
            first_exp_q <= '0;
            first_obs_q <= '0;
        end else begin
            first_vld_q <= first_vld_d;
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
        end
    end

    assign first_vld = first_vld_q;
    assign first_exp = first_exp_q;
    assign first_obs = first_obs_q;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: scoreboard bench; directed scenarios then randomized count-bus traffic.
module tb_counter_checker;

    localparam int Size      = 5;
    localparam int LockLen   = 4;
    localparam int ErrWidth  = 2;
    localparam int WrapWidth = 16;
    localparam int M         = 1 << Size;
    localparam int ERR_MAX   = (1 << ErrWidth) - 1;
    localparam int WRAP_MAX  = (1 << WrapWidth) - 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [Size-1:0]      count_in = '0;
    logic                 count_vld = 1'b0;
    logic                 dut_reset = 1'b0;
    logic                 locked;
    logic                 mismatch;
    logic [Size-1:0]      expected;
    logic [ErrWidth-1:0]  err_count;
    logic [WrapWidth-1:0] wrap_count;
`ifdef COUNTER_CHECKER_CAPTURE_EN
    logic                 first_vld;
    logic [Size-1:0]      first_exp;
    logic [Size-1:0]      first_obs;
`endif

    counter_checker #(
        .Size      (Size),
        .LockLen   (LockLen),
        .ErrWidth  (ErrWidth),
        .WrapWidth (WrapWidth)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .count_in   (count_in),
        .count_vld  (count_vld),
        .dut_reset  (dut_reset),
        .locked     (locked),
        .mismatch   (mismatch),
        .expected   (expected),
        .err_count  (err_count),
        .wrap_count (wrap_count)
`ifdef COUNTER_CHECKER_CAPTURE_EN
        ,
        .first_vld  (first_vld),
        .first_exp  (first_exp),
        .first_obs  (first_obs)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int lk; int mm; int ex; int er; int wr; int fv; int fe; int fo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_seen, m_lock, m_exp, m_streak, m_err, m_wrap, m_mm, m_fv, m_fe, m_fo;
    int c;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_seen = 0; m_lock = 0; m_exp = 0; m_streak = 0;
        m_err = 0; m_wrap = 0; m_mm = 0; m_fv = 0; m_fe = 0; m_fo = 0;
    endtask

    task automatic model_step(input int vld, input int val, input int drst);
        m_mm = 0;
        if (drst != 0) begin
            m_seen = 1; m_lock = 0; m_streak = 0; m_exp = 0;
        end else if (m_seen == 0) begin
            if (vld != 0) begin
                m_seen = 1; m_exp = (val + 1) % M; m_streak = 1;
                m_lock = (LockLen <= 1);
            end
        end else if (vld == 0) begin
            m_exp = (m_exp + 1) % M;
        end else if (val == m_exp) begin
            if (m_lock != 0) begin
                if (val == 0 && m_wrap < WRAP_MAX) m_wrap++;
            end else begin
                m_streak++;
                if (m_streak >= LockLen) m_lock = 1;
            end
            m_exp = (m_exp + 1) % M;
        end else begin
            if (m_lock != 0) begin
                m_mm = 1;
                if (m_err < ERR_MAX) m_err++;
                if (m_fv == 0) begin
                    m_fv = 1; m_fe = m_exp; m_fo = val;
                end
            end
            m_exp = (val + 1) % M; m_streak = 1;
            m_lock = (LockLen <= 1);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.lk = m_lock; e.mm = m_mm; e.ex = m_exp; e.er = m_err; e.wr = m_wrap;
        e.fv = m_fv; e.fe = m_fe; e.fo = m_fo;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input int vld, input int val, input int drst);
        reset     = 1'b0;
        count_vld = (vld != 0);
        count_in  = Size'(val);
        dut_reset = (drst != 0);
        model_step(vld, val, drst);
        push_exp();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        count_vld = 1'b0;
        dut_reset = 1'b0;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_expected", int'(expected), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_wrap", int'(wrap_count), 0);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("rst_first_vld", int'(first_vld), 0);
        chk("rst_first_exp", int'(first_exp), 0);
        chk("rst_first_obs", int'(first_obs), 0);
`endif
        model_reset();
        push_exp();
        @(negedge clock);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, c, 0);
            c = (c + 1) % M;
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("sb_locked", int'(locked), mon_e.lk);
            chk("sb_mismatch", int'(mismatch), mon_e.mm);
            chk("sb_expected", int'(expected), mon_e.ex);
            chk("sb_err", int'(err_count), mon_e.er);
            chk("sb_wrap", int'(wrap_count), mon_e.wr);
`ifdef COUNTER_CHECKER_CAPTURE_EN
            chk("sb_first_vld", int'(first_vld), mon_e.fv);
            chk("sb_first_exp", int'(first_exp), mon_e.fe);
            chk("sb_first_obs", int'(first_obs), mon_e.fo);
`endif
        end
    end

    initial begin
        int f_exp, f_obs, r, v;
        model_reset();
        c = 0;
        @(negedge clock);

        // 1: acquisition from a clean sequence
        apply_reset();
        send_clean(3);
        chk("t1_not_locked", int'(locked), 0);
        send_clean(1);
        chk("t1_locked", int'(locked), 1);
        chk("t1_no_mm", int'(mismatch), 0);

        // 2: two wraps while locked
        send_clean(61);
        chk("t2_wrap", int'(wrap_count), 2);
        chk("t2_err", int'(err_count), 0);

        // 3: inject 9 where 7 is expected, then relock
        send_clean(6);
        drive(1, 9, 0);
        c = 10;
        chk("t3_mm", int'(mismatch), 1);
        chk("t3_err", int'(err_count), 1);
        chk("t3_unlock", int'(locked), 0);
        send_clean(1);
        chk("t3_mm_pulse", int'(mismatch), 0);
        send_clean(3);
        chk("t3_relock", int'(locked), 1);
        chk("t3_err_hold", int'(err_count), 1);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("t3_first_exp", int'(first_exp), 7);
        chk("t3_first_obs", int'(first_obs), 9);
`endif

        // 4: observed counter reset for 3 cycles
        for (int i = 0; i < 3; i++) drive(1, 0, 1);
        chk("t4_unlock", int'(locked), 0);
        chk("t4_expected", int'(expected), 0);
        c = 0;
        send_clean(3);
        chk("t4_no_mm", int'(mismatch), 0);
        chk("t4_not_yet", int'(locked), 0);
        send_clean(1);
        chk("t4_relock", int'(locked), 1);
        chk("t4_err", int'(err_count), 1);

        // 5: count_vld low while counter keeps running
        for (int i = 0; i < 5; i++) begin
            drive(0, c, 0);
            c = (c + 1) % M;
        end
        send_clean(1);
        chk("t5_locked", int'(locked), 1);
        chk("t5_no_mm", int'(mismatch), 0);
        chk("t5_err", int'(err_count), 1);

        // 6: saturating error count, capture of first pair, async reset
        apply_reset();
        c = 20;
        send_clean(4);
        f_exp = c;
        f_obs = (c + 5) % M;
        for (int k = 0; k < 5; k++) begin
            v = (c + 5) % M;
            drive(1, v, 0);
            chk("t6_mm", int'(mismatch), 1);
            c = (v + 1) % M;
            send_clean(4);
        end
        chk("t6_err_sat", int'(err_count), 3);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("t6_first_vld", int'(first_vld), 1);
        chk("t6_first_exp", int'(first_exp), f_exp);
        chk("t6_first_obs", int'(first_obs), f_obs);
`endif
        send_clean(2);
        apply_reset();

        // Randomized traffic
        c = $urandom_range(0, M - 1);
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                apply_reset();
            end else if (r < 8) begin
                drive($urandom_range(0, 1), $urandom_range(0, M - 1), 1);
                c = 0;
            end else if (r < 16) begin
                drive(0, $urandom_range(0, M - 1), 0);
                c = (c + 1) % M;
            end else if (r < 21) begin
                v = $urandom_range(0, M - 1);
                drive(1, v, 0);
                if ($urandom_range(0, 1) == 1) c = (v + 1) % M;
                else c = (c + 1) % M;
            end else begin
                send_clean(1);
            end
        end

        @(posedge clock);
        #2;
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
